bfp_stage_ctrl: RTL and testbench

Sequences block-floating-point scaling across the radix-2 FFT stages.
- Tracks the maximum bit width of the input samples as they load, then of the butterfly outputs within each stage.
- Drives the init/bw_init and update/bw_new inputs of the BFP bit-width accumulator.
- Publishes the per-stage right-shift used by the butterfly datapath, plus stage index and done status.
- Sits between the sample loader / butterfly engine and the accumulator.

---
 rtl/bfp_stage_ctrl_pkg.sv | 29 ++
 rtl/bfp_stage_ctrl_if.sv | 43 ++++
 rtl/bfp_stage_ctrl_max_tracker.sv | 39 +++
 rtl/bfp_stage_ctrl.sv | 164 ++++++++++++++++
 tb/tb_bfp_stage_ctrl.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bfp_stage_ctrl_pkg.sv
// Shared types and helpers for the block-floating-point stage controller.
package bfp_pkg;

  // Controller phases, in frame order.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    INIT   = 3'd2,
    ARM    = 3'd3,
    STAGE  = 3'd4,
    COMMIT = 3'd5,
    FIN    = 3'd6
  } state_t;

  // Bits of headroom reserved for radix-2 butterfly growth.
  localparam int unsigned BFP_HEADROOM = 2;

  // Right-shift that restores the headroom for a value of width bw in a dw-bit datapath.
  function automatic logic [1:0] bfp_shift_of(input int unsigned bw, input int unsigned dw);
    if (bw >= dw - BFP_HEADROOM + 1) begin
      return 2'd2;
    end else if (bw == dw - BFP_HEADROOM) begin
      return 2'd1;
    end else begin
      return 2'd0;
    end
  endfunction

endpackage

// File: rtl/bfp_stage_ctrl_if.sv
// Bundle between the loader / butterfly engine / accumulator side and the controller.
//
// Handshake: there is no ready. load_valid and bfly_valid are single-cycle
// beats, each high cycle carries exactly one width and is consumed in that
// cycle when the controller is in the matching phase (LOAD / STAGE); any
// beat in another phase is dropped and flags err. init, update, stage_start
// and done are one-cycle pulses; bw_init / bw_new are valid with their pulse
// and hold afterwards.
interface bfp_stage_ctrl_if
  import bfp_pkg::*;
#(
  parameter int W      = 5,
  parameter int N_LOG2 = 10
);
  logic              start;
  logic              load_valid;
  logic [W-1:0]      load_bw;
  logic              bfly_valid;
  logic [W-1:0]      bfly_bw;
  logic              init;
  logic [W-1:0]      bw_init;
  logic              update;
  logic [W-1:0]      bw_new;
  logic              stage_start;
  logic [N_LOG2-1:0] stage_idx;
  logic [1:0]        stage_shift;
  logic              busy;
  logic              done;
  logic              err;
  state_t            state_dbg;

  modport master (
    output start, load_valid, load_bw, bfly_valid, bfly_bw,
    input  init, bw_init, update, bw_new, stage_start, stage_idx,
    input  stage_shift, busy, done, err, state_dbg
  );

  modport slave (
    input  start, load_valid, load_bw, bfly_valid, bfly_bw,
    output init, bw_init, update, bw_new, stage_start, stage_idx,
    output stage_shift, busy, done, err, state_dbg
  );
endinterface

// File: rtl/bfp_stage_ctrl_max_tracker.sv
// Running unsigned maximum of bit widths, saturated to the datapath width.
module bfp_max_tracker #(
  parameter int W  = 5,
  parameter int DW = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] bw,
  output logic [W-1:0] max_next,
  output logic         oor
);
  localparam logic [W-1:0] DW_W = W'(DW);

  logic [W-1:0] max_q;
  logic [W-1:0] max_d;
  logic [W-1:0] bw_sat;

  // Fold the saturated width into the max; max_next includes this cycle's beat.
  always_comb begin
    bw_sat   = (bw > DW_W) ? DW_W : bw;
    oor      = en && (bw > DW_W);
    max_next = max_q;
    if (en && (bw_sat > max_q)) begin
      max_next = bw_sat;
    end
    max_d = clr ? '0 : max_next;
  end

  // Running max register.
  always_ff @(posedge clk) begin
    if (reset) begin
      max_q <= '0;
    end else begin
      max_q <= max_d;
    end
  end
endmodule

// File: rtl/bfp_stage_ctrl.sv
// Sequences BFP scaling across the FFT stages: input max, per-stage max, shifts.
module bfp_stage_ctrl
  import bfp_pkg::*;
#(
  parameter int FFT_MAX_BIT_WIDTH = 5,
  parameter int FFT_DW            = 16,
  parameter int FFT_N_LOG2        = 10
) (
  input  logic             clk,
  input  logic             reset,
  bfp_stage_ctrl_if.slave  bus
);
  localparam int W = FFT_MAX_BIT_WIDTH;
  localparam int N = FFT_N_LOG2;
  localparam int unsigned DW_U = FFT_DW;
  localparam logic [N-1:0] LOAD_LAST  = '1;
  localparam logic [N-1:0] BFLY_LAST  = N'((1 << (N - 1)) - 1);
  localparam logic [N-1:0] STAGE_LAST = N'(N - 1);

  state_t       state_q, state_d;
  logic [N-1:0] load_cnt_q, load_cnt_d;
  logic [N-1:0] bfly_cnt_q, bfly_cnt_d;
  logic [N-1:0] stage_idx_q, stage_idx_d;
  logic [1:0]   stage_shift_q, stage_shift_d;
  logic [W-1:0] bw_init_q, bw_init_d;
  logic [W-1:0] bw_new_q, bw_new_d;
  logic         err_q, err_d;

  logic         trk_clr;
  logic         trk_en;
  logic [W-1:0] trk_bw;
  logic [W-1:0] trk_next;
  logic         trk_oor;
  logic         viol;
  logic         err_clr;

  // One tracker serves both phases; the FSM picks its source.
  bfp_max_tracker #(
    .W  (W),
    .DW (FFT_DW)
  ) u_max (
    .clk      (clk),
    .reset    (reset),
    .clr      (trk_clr),
    .en       (trk_en),
    .bw       (trk_bw),
    .max_next (trk_next),
    .oor      (trk_oor)
  );

  // Next-state, counters, latched widths/shift and sticky error.
  always_comb begin
    state_d       = state_q;
    load_cnt_d    = load_cnt_q;
    bfly_cnt_d    = bfly_cnt_q;
    stage_idx_d   = stage_idx_q;
    stage_shift_d = stage_shift_q;
    bw_init_d     = bw_init_q;
    bw_new_d      = bw_new_q;
    trk_clr       = 1'b0;
    trk_en        = 1'b0;
    trk_bw        = bus.load_bw;
    err_clr       = 1'b0;
    viol          = (bus.load_valid && (state_q != LOAD)) ||
                    (bus.bfly_valid && (state_q != STAGE));

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          trk_clr    = 1'b1;
          load_cnt_d = '0;
          bfly_cnt_d = '0;
          err_clr    = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        trk_en = bus.load_valid;
        trk_bw = bus.load_bw;
        if (bus.load_valid) begin
          load_cnt_d = load_cnt_q + N'(1);
          if (load_cnt_q == LOAD_LAST) begin
            bw_init_d = trk_next;
            state_d   = INIT;
          end
        end
      end
      INIT: begin
        stage_shift_d = bfp_shift_of(32'(bw_init_q), DW_U);
        trk_clr       = 1'b1;
        stage_idx_d   = '0;
        state_d       = ARM;
      end
      ARM: begin
        state_d = STAGE;
      end
      STAGE: begin
        trk_en = bus.bfly_valid;
        trk_bw = bus.bfly_bw;
        if (bus.bfly_valid) begin
          bfly_cnt_d = bfly_cnt_q + N'(1);
          if (bfly_cnt_q == BFLY_LAST) begin
            bw_new_d = trk_next;
            state_d  = COMMIT;
          end
        end
      end
      COMMIT: begin
        stage_shift_d = bfp_shift_of(32'(bw_new_q), DW_U);
        trk_clr       = 1'b1;
        bfly_cnt_d    = '0;
        if (stage_idx_q == STAGE_LAST) begin
          state_d = FIN;
        end else begin
          stage_idx_d = stage_idx_q + N'(1);
          state_d     = ARM;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    err_d = err_clr ? 1'b0 : (err_q | viol | trk_oor);
  end

  // Controller registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      load_cnt_q    <= '0;
      bfly_cnt_q    <= '0;
      stage_idx_q   <= '0;
      stage_shift_q <= '0;
      bw_init_q     <= '0;
      bw_new_q      <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      load_cnt_q    <= load_cnt_d;
      bfly_cnt_q    <= bfly_cnt_d;
      stage_idx_q   <= stage_idx_d;
      stage_shift_q <= stage_shift_d;
      bw_init_q     <= bw_init_d;
      bw_new_q      <= bw_new_d;
      err_q         <= err_d;
    end
  end

  assign bus.init        = (state_q == INIT);
  assign bus.update      = (state_q == COMMIT);
  assign bus.stage_start = (state_q == ARM);
  assign bus.done        = (state_q == FIN);
  assign bus.busy        = (state_q != IDLE);
  assign bus.bw_init     = bw_init_q;
  assign bus.bw_new      = bw_new_q;
  assign bus.stage_idx   = stage_idx_q;
  assign bus.stage_shift = stage_shift_q;
  assign bus.err         = err_q;
  assign bus.state_dbg   = state_q;
endmodule

// File: tb/tb_bfp_stage_ctrl.sv
// Directed bench for bfp_stage_ctrl with an 8-point (3-stage) FFT configuration.
module tb_bfp_stage_ctrl;
  import bfp_pkg::*;

  localparam int W  = 5;
  localparam int DW = 16;
  localparam int NL = 3;

  // Clock and reset.
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bfp_stage_ctrl_if #(.W(W), .N_LOG2(NL)) bus ();

  bfp_stage_ctrl #(
    .FFT_MAX_BIT_WIDTH (W),
    .FFT_DW            (DW),
    .FFT_N_LOG2        (NL)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int n_init   = 0;
  int n_upd    = 0;
  int n_done   = 0;

  // Scoreboard of expected bw_new values, popped on each update pulse.
  logic [W-1:0] exp_q[$];

  // Current frame vectors and hand-computed expectations.
  logic [W-1:0] ld[8];
  logic [W-1:0] bf[3][4];
  logic [W-1:0] exp_init;
  logic [1:0]   exp_sh_init;
  logic [W-1:0] exp_new[3];
  logic [1:0]   exp_sh[3];
  logic         exp_err_load;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample 1 time unit after the edge and score pulses.
  task automatic tick();
    @(posedge clk);
    #1;
    if (bus.init) n_init++;
    if (bus.done) n_done++;
    if (bus.update) begin
      n_upd++;
      if (exp_q.size() == 0) chk("sb_unexpected_update", 32'd1, 32'd0);
      else chk("sb_bw_new", 32'(bus.bw_new), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic gap(input bit gapped);
    if (gapped) repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic run_frame(input bit gapped, input bit arm_poke, input bit start_poke,
                           input bit abort);
    int  i0, u0, d0;
    logic e;
    i0 = n_init; u0 = n_upd; d0 = n_done;
    e  = exp_err_load;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("enter_load", 32'(bus.state_dbg), 32'(LOAD));
    chk("err_cleared_by_start", 32'(bus.err), 32'd0);
    for (int i = 0; i < 8; i++) begin
      gap(gapped);
      bus.load_valid = 1'b1;
      bus.load_bw    = ld[i];
      tick();
      bus.load_valid = 1'b0;
    end
    chk("init_pulse", 32'(bus.init), 32'd1);
    chk("bw_init", 32'(bus.bw_init), 32'(exp_init));
    chk("err_after_load", 32'(bus.err), 32'(e));
    tick();
    for (int s = 0; s < 3; s++) begin
      chk("stage_start", 32'(bus.stage_start), 32'd1);
      chk("stage_idx_arm", 32'(bus.stage_idx), s);
      chk("shift_arm", 32'(bus.stage_shift), 32'((s == 0) ? exp_sh_init : exp_sh[s-1]));
      exp_q.push_back(exp_new[s]);
      if (arm_poke && s == 0) begin
        bus.bfly_valid = 1'b1;
        bus.bfly_bw    = 5'd15;
        tick();
        bus.bfly_valid = 1'b0;
        chk("err_bfly_in_arm", 32'(bus.err), 32'd1);
        e = 1'b1;
      end else begin
        tick();
      end
      chk("in_stage", 32'(bus.state_dbg), 32'(STAGE));
      for (int b = 0; b < 4; b++) begin
        gap(gapped);
        bus.bfly_valid = 1'b1;
        bus.bfly_bw    = bf[s][b];
        if (start_poke && s == 1 && b == 1) bus.start = 1'b1;
        tick();
        bus.bfly_valid = 1'b0;
        bus.start      = 1'b0;
        if (start_poke && s == 1 && b == 1) begin
          chk("start_ignored_state", 32'(bus.state_dbg), 32'(STAGE));
          chk("start_ignored_err", 32'(bus.err), 32'(e));
          chk("start_ignored_idx", 32'(bus.stage_idx), 32'd1);
        end
        if (abort && s == 1 && b == 1) begin
          reset = 1'b1;
          tick();
          reset = 1'b0;
          exp_q.delete();
          chk("abort_state", 32'(bus.state_dbg), 32'(IDLE));
          chk("abort_outputs", {bus.init, bus.update, bus.stage_start, bus.done, bus.busy,
                                bus.err, bus.stage_shift}, 32'd0);
          chk("abort_bw", {bus.bw_init, bus.bw_new, bus.stage_idx}, 32'd0);
          chk("abort_updates", n_upd - u0, 32'd1);
          chk("abort_no_done", n_done - d0, 32'd0);
          return;
        end
      end
      chk("update_pulse", 32'(bus.update), 32'd1);
      chk("bw_new", 32'(bus.bw_new), 32'(exp_new[s]));
      chk("stage_idx_commit", 32'(bus.stage_idx), s);
      tick();
    end
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("shift_fin", 32'(bus.stage_shift), 32'(exp_sh[2]));
    tick();
    chk("busy_low", 32'(bus.busy), 32'd0);
    chk("done_once", 32'(bus.done), 32'd0);
    chk("bw_new_hold", 32'(bus.bw_new), 32'(exp_new[2]));
    chk("bw_init_hold", 32'(bus.bw_init), 32'(exp_init));
    chk("err_final", 32'(bus.err), 32'(e));
    chk("cnt_init", n_init - i0, 32'd1);
    chk("cnt_update", n_upd - u0, 32'd3);
    chk("cnt_done", n_done - d0, 32'd1);
  endtask

  task automatic set_nominal();
    ld           = '{5'd4, 5'd12, 5'd7, 5'd1, 5'd11, 5'd0, 5'd12, 5'd9};
    bf[0]        = '{5'd10, 5'd14, 5'd3, 5'd8};
    bf[1]        = '{5'd15, 5'd2, 5'd11, 5'd6};
    bf[2]        = '{5'd5, 5'd9, 5'd1, 5'd7};
    exp_init     = 5'd12; exp_sh_init = 2'd0;
    exp_new      = '{5'd14, 5'd15, 5'd9};
    exp_sh       = '{2'd1, 2'd2, 2'd0};
    exp_err_load = 1'b0;
  endtask

  // Directed sequence.
  initial begin
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_bw    = '0;
    bus.bfly_valid = 1'b0;
    bus.bfly_bw    = '0;
    tick();
    tick();
    chk("reset_state", 32'(bus.state_dbg), 32'(IDLE));
    chk("reset_outputs", {bus.init, bus.update, bus.stage_start, bus.done, bus.busy,
                          bus.err, bus.stage_shift}, 32'd0);
    chk("reset_bw", {bus.bw_init, bus.bw_new, bus.stage_idx}, 32'd0);
    reset = 1'b0;
    tick();

    // Nominal back-to-back frame.
    set_nominal();
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Maximum carried only by the final beat of each phase.
    ld           = '{5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd3, 5'd16};
    bf[0]        = '{5'd2, 5'd2, 5'd2, 5'd13};
    bf[1]        = '{5'd1, 5'd1, 5'd1, 5'd14};
    bf[2]        = '{5'd4, 5'd4, 5'd4, 5'd15};
    exp_init     = 5'd16; exp_sh_init = 2'd2;
    exp_new      = '{5'd13, 5'd14, 5'd15};
    exp_sh       = '{2'd0, 2'd1, 2'd2};
    exp_err_load = 1'b0;
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Out-of-range load width saturates and flags err.
    ld           = '{5'd20, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5, 5'd5};
    bf[0]        = '{5'd5, 5'd6, 5'd7, 5'd8};
    bf[1]        = '{5'd8, 5'd7, 5'd6, 5'd5};
    bf[2]        = '{5'd14, 5'd1, 5'd1, 5'd1};
    exp_init     = 5'd16; exp_sh_init = 2'd2;
    exp_new      = '{5'd8, 5'd8, 5'd14};
    exp_sh       = '{2'd0, 2'd0, 2'd1};
    exp_err_load = 1'b1;
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Butterfly beat during ARM is dropped and flags err.
    ld           = '{5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4, 5'd4};
    bf[0]        = '{5'd5, 5'd5, 5'd5, 5'd5};
    bf[1]        = '{5'd6, 5'd6, 5'd6, 5'd6};
    bf[2]        = '{5'd7, 5'd7, 5'd7, 5'd7};
    exp_init     = 5'd4; exp_sh_init = 2'd0;
    exp_new      = '{5'd5, 5'd6, 5'd7};
    exp_sh       = '{2'd0, 2'd0, 2'd0};
    exp_err_load = 1'b0;
    run_frame(1'b0, 1'b1, 1'b0, 1'b0);

    // start while busy is ignored.
    set_nominal();
    run_frame(1'b0, 1'b0, 1'b1, 1'b0);

    // Reset during stage 1, then a clean frame.
    set_nominal();
    run_frame(1'b0, 1'b0, 1'b0, 1'b1);
    set_nominal();
    run_frame(1'b0, 1'b0, 1'b0, 1'b0);

    // Gapped handshakes give the same results as back-to-back.
    set_nominal();
    run_frame(1'b1, 1'b0, 1'b0, 1'b0);

    // Load beat while idle flags err without starting a frame.
    bus.load_valid = 1'b1;
    bus.load_bw    = 5'd3;
    tick();
    bus.load_valid = 1'b0;
    chk("idle_load_err", 32'(bus.err), 32'd1);
    chk("idle_load_state", 32'(bus.state_dbg), 32'(IDLE));

    chk("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
